// File: rtl/fetch_queue_stage_pkg.sv
// Shared fetch-side types: machine word, decoded fetch packet and fetch FSM state.
package lc3b_types;

  localparam int LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
    lc3b_word pc_plus2;
    lc3b_word predicted_pc;
    logic     taken;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// DEPTH-entry fetch packet FIFO; storage is reset so the head reads zero after reset.
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_pkt_t             push_pkt,
  input  logic                   pop,
  output fetch_pkt_t             head_pkt,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;

  // Popping an empty queue is ignored rather than underflowing.
  assign pop_ok     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_pkt   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_pkt;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: one outstanding imem request at a time, decoded packets queued for decode.
module fetch_queue_stage
  import lc3b_types::*;
#(
  parameter int                WORD_W     = 16,
  parameter int                LINE_WORDS = 8,
  parameter int                DEPTH      = 4,
  parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       control_flush,
  input  logic [WORD_W-1:0]          new_pc,
  output logic [WORD_W-1:0]          fetch_pc,
  input  logic                       pred_taken,
  input  logic [WORD_W-1:0]          pred_target,
  output logic [WORD_W-1:0]          imem_address,
  output logic                       imem_action_stb,
  output logic                       imem_action_cyc,
  input  logic [WORD_W*LINE_WORDS-1:0] imem_rdata,
  input  logic                       imem_resp,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WORD_W-1:0]          deq_instr,
  output logic [WORD_W-1:0]          deq_pc,
  output logic [WORD_W-1:0]          deq_pc_plus2,
  output logic [WORD_W-1:0]          deq_predicted_pc,
  output logic                       deq_taken,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_state_e               fetch_state
);

  localparam int SEL_W = $clog2(LINE_WORDS);
  localparam int CW    = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] req_addr;
  logic [SEL_W-1:0]  sel;
  fetch_pkt_t        new_pkt;
  fetch_pkt_t        head_pkt;
  logic              push;
  logic              pop;
  logic [CW-1:0]     post_count;

  // Word address within the line; bit 0 is the byte offset inside a word.
  assign sel = req_addr[SEL_W:1];

  always_comb begin
    new_pkt              = '0;
    new_pkt.instr        = imem_rdata[sel*WORD_W +: WORD_W];
    new_pkt.pc           = req_addr;
    new_pkt.pc_plus2     = req_addr + WORD_W'(2);
    new_pkt.taken        = pred_taken;
    new_pkt.predicted_pc = pred_taken ? pred_target : new_pkt.pc_plus2;
  end

  assign push       = (state == FS_REQ) && imem_resp && !control_flush;
  assign pop        = deq_valid && deq_ready;
  assign post_count = count + CW'(1) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        FS_IDLE: begin
          if (control_flush) begin
            pc <= new_pc;
          end else if (count < CW'(DEPTH)) begin
            req_addr <= pc;
            state    <= FS_REQ;
          end
        end
        FS_REQ: begin
          if (control_flush) begin
            pc    <= new_pc;
            state <= imem_resp ? FS_IDLE : FS_DROP;
          end else if (imem_resp) begin
            pc <= new_pkt.predicted_pc;
            // Back-to-back issue keeps one instruction per cycle while there is room.
            if (post_count < CW'(DEPTH)) req_addr <= new_pkt.predicted_pc;
            else                         state    <= FS_IDLE;
          end
        end
        FS_DROP: begin
          if (control_flush) pc <= new_pc;
          if (imem_resp) state <= FS_IDLE;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (control_flush),
    .push       (push),
    .push_pkt   (new_pkt),
    .pop        (pop),
    .head_pkt   (head_pkt),
    .head_valid (deq_valid),
    .count      (count)
  );

  assign imem_action_stb  = (state != FS_IDLE);
  assign imem_action_cyc  = (state != FS_IDLE);
  assign imem_address     = req_addr;
  assign fetch_pc         = req_addr;
  assign fetch_state      = state;
  assign deq_instr        = head_pkt.instr;
  assign deq_pc           = head_pkt.pc;
  assign deq_pc_plus2     = head_pkt.pc_plus2;
  assign deq_predicted_pc = head_pkt.predicted_pc;
  assign deq_taken        = head_pkt.taken;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: reset, fetch, prediction, backpressure, flushes, boundaries.
module tb_fetch_queue_stage;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         control_flush;
  logic [15:0]  new_pc;
  logic [15:0]  fetch_pc;
  logic         pred_taken;
  logic [15:0]  pred_target;
  logic [15:0]  imem_address;
  logic         imem_action_stb;
  logic         imem_action_cyc;
  logic [127:0] imem_rdata;
  logic         imem_resp;
  logic         deq_valid;
  logic         deq_ready;
  logic [15:0]  deq_instr;
  logic [15:0]  deq_pc;
  logic [15:0]  deq_pc_plus2;
  logic [15:0]  deq_predicted_pc;
  logic         deq_taken;
  logic [2:0]   count;
  fetch_state_e fetch_state;

  logic         pred_on;
  logic [15:0]  pred_pc;
  logic [15:0]  pred_tgt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Predictor stub: taken only for one chosen fetch address.
  assign pred_taken  = pred_on && (fetch_pc == pred_pc);
  assign pred_target = pred_tgt;

  fetch_queue_stage #(
    .WORD_W(16), .LINE_WORDS(8), .DEPTH(4), .RESET_PC(16'h0040)
  ) dut (
    .clk(clk), .rst_n(rst_n), .control_flush(control_flush), .new_pc(new_pc),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .imem_address(imem_address), .imem_action_stb(imem_action_stb),
    .imem_action_cyc(imem_action_cyc), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .deq_pc_plus2(deq_pc_plus2), .deq_predicted_pc(deq_predicted_pc), .deq_taken(deq_taken),
    .count(count), .fetch_state(fetch_state)
  );

  function automatic logic [127:0] make_line(input logic [15:0] base);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = base + 16'(i);
    return l;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; control_flush = 1'b0; new_pc = '0; imem_rdata = '0; imem_resp = 1'b0;
    deq_ready = 1'b0; pred_on = 1'b0; pred_pc = '0; pred_tgt = '0;
    repeat (2) step();
    tests++; if (imem_action_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", imem_action_stb); end
    tests++; if (imem_address !== 16'h0040) begin fails++; $display("FAIL reset_addr: got %h want 0040", imem_address); end
    tests++; if (deq_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL reset_queue: valid %b count %0d want 0 0", deq_valid, count); end
    tests++; if (deq_instr !== 16'h0000 || deq_taken !== 1'b0) begin fails++; $display("FAIL reset_head: instr %h taken %b want 0000 0", deq_instr, deq_taken); end
    tests++; if (fetch_state !== FS_IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", fetch_state); end
    rst_n = 1'b1;
    step();
    tests++; if (imem_action_stb !== 1'b1 || imem_action_cyc !== 1'b1) begin fails++; $display("FAIL first_stb: stb %b cyc %b want 1 1", imem_action_stb, imem_action_cyc); end
    tests++; if (imem_address !== 16'h0040 || fetch_pc !== 16'h0040) begin fails++; $display("FAIL first_addr: addr %h pc %h want 0040", imem_address, fetch_pc); end
  endtask

  task automatic test_first_fetch();
    imem_resp = 1'b1; imem_rdata = make_line(16'h1234);
    step();
    imem_resp = 1'b0;
    tests++; if (deq_valid !== 1'b1 || deq_instr !== 16'h1234) begin fails++; $display("FAIL ff_instr: valid %b instr %h want 1 1234", deq_valid, deq_instr); end
    tests++; if (deq_pc !== 16'h0040 || deq_pc_plus2 !== 16'h0042) begin fails++; $display("FAIL ff_pc: pc %h plus2 %h want 0040 0042", deq_pc, deq_pc_plus2); end
    tests++; if (deq_predicted_pc !== 16'h0042 || deq_taken !== 1'b0) begin fails++; $display("FAIL ff_pred: ppc %h taken %b want 0042 0", deq_predicted_pc, deq_taken); end
    tests++; if (imem_address !== 16'h0042 || count !== 3'd1) begin fails++; $display("FAIL ff_next: addr %h count %0d want 0042 1", imem_address, count); end
  endtask

  task automatic test_predict();
    pred_on = 1'b1; pred_pc = 16'h0042; pred_tgt = 16'h0100;
    imem_resp = 1'b1; imem_rdata = make_line(16'h2000); deq_ready = 1'b1;
    step();
    imem_resp = 1'b0; deq_ready = 1'b0; pred_on = 1'b0;
    tests++; if (deq_taken !== 1'b1 || deq_predicted_pc !== 16'h0100) begin fails++; $display("FAIL pred_pkt: taken %b ppc %h want 1 0100", deq_taken, deq_predicted_pc); end
    tests++; if (deq_instr !== 16'h2001 || deq_pc !== 16'h0042) begin fails++; $display("FAIL pred_head: instr %h pc %h want 2001 0042", deq_instr, deq_pc); end
    tests++; if (imem_address !== 16'h0100 || count !== 3'd1) begin fails++; $display("FAIL pred_next: addr %h count %0d want 0100 1", imem_address, count); end
  endtask

  task automatic test_back_to_back();
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drain: count %0d want 0", count); end
    imem_resp = 1'b1; imem_rdata = make_line(16'h3000);
    repeat (6) step();
    imem_resp = 1'b0;
    tests++; if (count !== 3'd4 || imem_action_stb !== 1'b0) begin fails++; $display("FAIL b2b_full: count %0d stb %b want 4 0", count, imem_action_stb); end
    tests++; if (deq_pc !== 16'h0100 || deq_instr !== 16'h3000) begin fails++; $display("FAIL b2b_head: pc %h instr %h want 0100 3000", deq_pc, deq_instr); end
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    step();
    tests++; if (imem_action_stb !== 1'b1 || imem_address !== 16'h0108) begin fails++; $display("FAIL b2b_resume: stb %b addr %h want 1 0108", imem_action_stb, imem_address); end
    tests++; if (count !== 3'd3 || deq_pc !== 16'h0102 || deq_instr !== 16'h3001) begin fails++; $display("FAIL b2b_pop: count %0d pc %h instr %h want 3 0102 3001", count, deq_pc, deq_instr); end
  endtask

  task automatic test_flush_drop();
    control_flush = 1'b1; new_pc = 16'h0200;
    step();
    control_flush = 1'b0;
    tests++; if (fetch_state !== FS_DROP || imem_action_stb !== 1'b1 || imem_address !== 16'h0108) begin fails++; $display("FAIL drop_hold: state %0d stb %b addr %h want DROP 1 0108", fetch_state, imem_action_stb, imem_address); end
    tests++; if (count !== 3'd0 || deq_valid !== 1'b0) begin fails++; $display("FAIL drop_clear: count %0d valid %b want 0 0", count, deq_valid); end
    step();
    tests++; if (imem_action_stb !== 1'b1 || imem_address !== 16'h0108) begin fails++; $display("FAIL drop_wait: stb %b addr %h want 1 0108", imem_action_stb, imem_address); end
    imem_resp = 1'b1; imem_rdata = make_line(16'h7000);
    step();
    imem_resp = 1'b0;
    tests++; if (count !== 3'd0 || deq_valid !== 1'b0 || imem_action_stb !== 1'b0) begin fails++; $display("FAIL drop_discard: count %0d valid %b stb %b want 0 0 0", count, deq_valid, imem_action_stb); end
    step();
    tests++; if (imem_action_stb !== 1'b1 || imem_address !== 16'h0200) begin fails++; $display("FAIL drop_redirect: stb %b addr %h want 1 0200", imem_action_stb, imem_address); end
  endtask

  task automatic test_flush_resp();
    imem_resp = 1'b1; imem_rdata = make_line(16'h4000);
    step();
    tests++; if (deq_valid !== 1'b1 || count !== 3'd1 || deq_instr !== 16'h4000) begin fails++; $display("FAIL fr_pre: valid %b count %0d instr %h want 1 1 4000", deq_valid, count, deq_instr); end
    control_flush = 1'b1; new_pc = 16'h0300; deq_ready = 1'b1;
    step();
    control_flush = 1'b0; deq_ready = 1'b0; imem_resp = 1'b0;
    tests++; if (count !== 3'd0 || deq_valid !== 1'b0 || imem_action_stb !== 1'b0) begin fails++; $display("FAIL fr_clear: count %0d valid %b stb %b want 0 0 0", count, deq_valid, imem_action_stb); end
    step();
    tests++; if (imem_action_stb !== 1'b1 || imem_address !== 16'h0300) begin fails++; $display("FAIL fr_redirect: stb %b addr %h want 1 0300", imem_action_stb, imem_address); end
  endtask

  task automatic test_boundaries();
    control_flush = 1'b1; new_pc = 16'h000E; imem_resp = 1'b1;
    step();
    control_flush = 1'b0; imem_resp = 1'b0;
    step();
    tests++; if (imem_address !== 16'h000E) begin fails++; $display("FAIL bd_addr_e: got %h want 000E", imem_address); end
    imem_resp = 1'b1; imem_rdata = make_line(16'h5000);
    step();
    imem_resp = 1'b0;
    tests++; if (deq_instr !== 16'h5007 || deq_pc !== 16'h000E || deq_pc_plus2 !== 16'h0010) begin fails++; $display("FAIL bd_word7: instr %h pc %h plus2 %h want 5007 000E 0010", deq_instr, deq_pc, deq_pc_plus2); end
    control_flush = 1'b1; new_pc = 16'hFFFE; imem_resp = 1'b1;
    step();
    control_flush = 1'b0; imem_resp = 1'b0;
    step();
    tests++; if (imem_address !== 16'hFFFE) begin fails++; $display("FAIL bd_addr_top: got %h want FFFE", imem_address); end
    imem_resp = 1'b1; imem_rdata = make_line(16'h6000);
    step();
    imem_resp = 1'b0;
    tests++; if (deq_instr !== 16'h6007 || deq_pc !== 16'hFFFE) begin fails++; $display("FAIL bd_top_head: instr %h pc %h want 6007 FFFE", deq_instr, deq_pc); end
    tests++; if (deq_pc_plus2 !== 16'h0000 || deq_predicted_pc !== 16'h0000 || imem_address !== 16'h0000) begin fails++; $display("FAIL bd_wrap: plus2 %h ppc %h addr %h want 0000 0000 0000", deq_pc_plus2, deq_predicted_pc, imem_address); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_predict();
    test_back_to_back();
    test_flush_drop();
    test_flush_resp();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
